julia_pixel_engine: RTL and testbench

//  Per-pixel iteration controller that sits directly upstream of z_calculator and consumes its outputs.
//  - Accepts one pixel job (z0, c, tag).
//  - Registers z and the iteration count, feeds them back through z_calculator each cycle.
//  - Detects termination and presents the final iteration count, with the tag, to the colour/writeback stage.
//  - One pixel in flight at a time; valid/ready on both sides.

---
 rtl/julia_pkg.sv | 12 +
 rtl/z_calculator.sv | 48 ++++
 rtl/julia_pixel_engine.sv | 127 ++++++++++++
 tb/tb_julia_pixel_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared fixed-point geometry, escape threshold and FSM state encoding for the Julia pixel engine.
package julia_pkg;
  localparam int FRACTIONAL    = 10;
  localparam int INTEGRAL      = 10;
  localparam int WIDTH         = INTEGRAL + FRACTIONAL;
  localparam int MAX_ITER      = 255;
  localparam int TAG_W         = 19;
  localparam int ITER_W        = 8;
  localparam int ESCAPE_THRESH = 4 << FRACTIONAL;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
endpackage

// File: rtl/z_calculator.sv
// One Julia step z' = z^2 + c in wrapping fixed point; combinational, no handshake.
// iteration_out repeats iteration_in when z' escapes (|z'|^2 >= 4.0) or c == 0, else increments.
module z_calculator
  import julia_pkg::*;
#(
  parameter int WIDTH      = julia_pkg::WIDTH,
  parameter int FRACTIONAL = julia_pkg::FRACTIONAL
) (
  input  logic [WIDTH-1:0]  z_real_in,
  input  logic [WIDTH-1:0]  z_imag_in,
  input  logic [WIDTH-1:0]  c_real_in,
  input  logic [WIDTH-1:0]  c_imag_in,
  input  logic [ITER_W-1:0] iteration_in,
  output logic [WIDTH-1:0]  z_real_out,
  output logic [WIDTH-1:0]  z_imag_out,
  output logic [ITER_W-1:0] iteration_out
);
  localparam logic [2*WIDTH:0] THRESH_SQ = (2*WIDTH+1)'(ESCAPE_THRESH) << FRACTIONAL;

  logic signed [WIDTH-1:0]   zr, zi, zor, zoi;
  logic signed [2*WIDTH-1:0] sq_r, sq_i, x_ri, so_r, so_i;
  logic signed [2*WIDTH:0]   diff, dbl;
  logic        [2*WIDTH:0]   mag;
  logic                      escaped, c_zero;

  assign zr   = z_real_in;
  assign zi   = z_imag_in;
  assign sq_r = (2*WIDTH)'(zr) * (2*WIDTH)'(zr);
  assign sq_i = (2*WIDTH)'(zi) * (2*WIDTH)'(zi);
  assign x_ri = (2*WIDTH)'(zr) * (2*WIDTH)'(zi);

  // One guard bit so 2*zr*zi and the difference of squares never overflow before rescaling.
  assign diff = (2*WIDTH+1)'(sq_r) - (2*WIDTH+1)'(sq_i);
  assign dbl  = (2*WIDTH+1)'(x_ri) <<< 1;

  assign z_real_out = WIDTH'(diff >>> FRACTIONAL) + c_real_in;
  assign z_imag_out = WIDTH'(dbl >>> FRACTIONAL) + c_imag_in;

  assign zor  = z_real_out;
  assign zoi  = z_imag_out;
  assign so_r = (2*WIDTH)'(zor) * (2*WIDTH)'(zor);
  assign so_i = (2*WIDTH)'(zoi) * (2*WIDTH)'(zoi);
  assign mag  = {1'b0, so_r} + {1'b0, so_i};

  assign escaped       = (mag >= THRESH_SQ);
  assign c_zero        = (c_real_in == '0) && (c_imag_in == '0);
  assign iteration_out = (escaped || c_zero) ? iteration_in : iteration_in + ITER_W'(1);
endmodule

// File: rtl/julia_pixel_engine.sv
// Iterates one pixel job through z_calculator until escape or MAX_ITER, then holds count+tag.
// Result appears 2+k cycles after accept (1+MAX_ITER at cap); out_ready=0 holds DONE and blocks new jobs.
module julia_pixel_engine
  import julia_pkg::*;
#(
  parameter int WIDTH      = julia_pkg::WIDTH,
  parameter int FRACTIONAL = julia_pkg::FRACTIONAL,
  parameter int MAX_ITER   = julia_pkg::MAX_ITER,
  parameter int TAG_W      = julia_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  z0_real_in,
  input  logic [WIDTH-1:0]  z0_imag_in,
  input  logic [WIDTH-1:0]  c_real_in,
  input  logic [WIDTH-1:0]  c_imag_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] iter_count_out,
  output logic [TAG_W-1:0]  tag_out
);
  localparam logic [ITER_W-1:0] MAX_Q = ITER_W'(MAX_ITER);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  z_r_q, z_r_d, z_i_q, z_i_d;
  logic [WIDTH-1:0]  c_r_q, c_r_d, c_i_q, c_i_d;
  logic [TAG_W-1:0]  tag_q, tag_d, out_tag_q, out_tag_d;
  logic [ITER_W-1:0] iter_q, iter_d, count_q, count_d;
  logic [WIDTH-1:0]  z_r_nxt, z_i_nxt;
  logic [ITER_W-1:0] iter_nxt;

  z_calculator #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_zcalc (
    .z_real_in     (z_r_q),
    .z_imag_in     (z_i_q),
    .c_real_in     (c_r_q),
    .c_imag_in     (c_i_q),
    .iteration_in  (iter_q),
    .z_real_out    (z_r_nxt),
    .z_imag_out    (z_i_nxt),
    .iteration_out (iter_nxt)
  );

  always_comb begin
    state_d   = state_q;
    z_r_d     = z_r_q;
    z_i_d     = z_i_q;
    c_r_d     = c_r_q;
    c_i_d     = c_i_q;
    tag_d     = tag_q;
    iter_d    = iter_q;
    count_d   = count_q;
    out_tag_d = out_tag_q;
    if (abort) begin
      state_d   = IDLE;
      iter_d    = '0;
      count_d   = '0;
      out_tag_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            z_r_d   = z0_real_in;
            z_i_d   = z0_imag_in;
            c_r_d   = c_real_in;
            c_i_d   = c_imag_in;
            tag_d   = tag_in;
            iter_d  = '0;
            state_d = ITER;
          end
        end
        ITER: begin
          // An unchanged count means escape (or c == 0): that takes priority over the cap.
          if (iter_nxt == iter_q) begin
            count_d   = iter_q;
            out_tag_d = tag_q;
            state_d   = DONE;
          end else if (iter_nxt == MAX_Q) begin
            count_d   = MAX_Q;
            out_tag_d = tag_q;
            state_d   = DONE;
          end else begin
            z_r_d  = z_r_nxt;
            z_i_d  = z_i_nxt;
            iter_d = iter_nxt;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      z_r_q     <= '0;
      z_i_q     <= '0;
      c_r_q     <= '0;
      c_i_q     <= '0;
      tag_q     <= '0;
      iter_q    <= '0;
      count_q   <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      z_r_q     <= z_r_d;
      z_i_q     <= z_i_d;
      c_r_q     <= c_r_d;
      c_i_q     <= c_i_d;
      tag_q     <= tag_d;
      iter_q    <= iter_d;
      count_q   <= count_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign iter_count_out = count_q;
  assign tag_out        = out_tag_q;
endmodule

// File: tb/tb_julia_pixel_engine.sv
// Scoreboard bench: the monitor predicts each accepted job's count and latency from a plain
// integer model of the Julia recurrence and checks the result handshake against it.
module tb_julia_pixel_engine;
  localparam int W    = 20;
  localparam int F    = 10;
  localparam int MAXI = 255;
  localparam int TW   = 19;

  logic          clk = 1'b0;
  logic          n_rst, abort, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  z0r, z0i, cr, ci;
  logic [TW-1:0] tag;
  logic [7:0]    iter_count_out;
  logic [TW-1:0] tag_out;

  typedef struct {
    int cnt;
    int tag;
    int t_acc;
    int lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  int   rdy_mode = 1;

  julia_pixel_engine dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .abort          (abort),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .z0_real_in     (z0r),
    .z0_imag_in     (z0i),
    .c_real_in      (cr),
    .c_imag_in      (ci),
    .tag_in         (tag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .iter_count_out (iter_count_out),
    .tag_out        (tag_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, req, edge_n);
    end
  endtask

  function automatic longint wrap(input longint v);
    longint r;
    r = v & longint'((1 << W) - 1);
    if (r >= longint'(1 << (W - 1))) r = r - longint'(1 << W);
    return r;
  endfunction

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Plain-arithmetic Julia iteration: count of steps before z escapes |z|^2 >= 4.
  function automatic int model(input longint zr0, input longint zi0, input longint cre, input longint cim);
    longint zr, zi, nr, ni;
    zr = zr0;
    zi = zi0;
    for (int it = 0; it < MAXI; it++) begin
      nr = wrap(((zr * zr - zi * zi) >>> F) + cre);
      ni = wrap(((2 * zr * zi) >>> F) + cim);
      if ((cre == 0 && cim == 0) || (nr * nr + ni * ni >= (longint'(4) << (2 * F)))) return it;
      if (it + 1 == MAXI) return MAXI;
      zr = nr;
      zi = ni;
    end
    return MAXI;
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: predicts at the interface, pops and compares on every result handshake.
  initial begin
    bit   seen_valid;
    bit   hs_prev;
    exp_t e;
    seen_valid = 0;
    hs_prev    = 0;
    forever begin
      @(negedge clk);
      if (hs_prev) check("bubble_in_ready", in_ready, 1);
      hs_prev = 0;
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          if (!seen_valid) begin
            check("latency", edge_n + 1, sbq[0].t_acc + sbq[0].lat);
            seen_valid = 1;
          end
          check("iter_count", iter_count_out, sbq[0].cnt);
          check("tag", tag_out, sbq[0].tag);
          check("in_ready_while_done", in_ready, 0);
          if (out_ready && n_rst) begin
            void'(sbq.pop_front());
            seen_valid = 0;
            hs_prev    = 1;
          end
        end
      end
      if (!n_rst || abort) begin
        sbq.delete();
        seen_valid = 0;
      end
      if (in_valid && in_ready && !abort && n_rst) begin
        e.cnt   = model(sx(z0r), sx(z0i), sx(cr), sx(ci));
        e.tag   = int'(tag);
        e.t_acc = edge_n + 1;
        e.lat   = (e.cnt < MAXI) ? 2 + e.cnt : 1 + MAXI;
        sbq.push_back(e);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d, input logic [TW-1:0] t);
    bit will;
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    z0r = a; z0i = b; cr = c; ci = d; tag = t;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk);
      will = in_ready && !abort && n_rst;
      @(posedge clk);
      #1;
      if (will) acc = 1;
    end
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && sbq.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_timeout", sbq.size(), 0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_out_valid", out_valid, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra, rb, rc, rd;
    n_rst = 1'b0; abort = 1'b0; in_valid = 1'b0;
    z0r = '0; z0i = '0; cr = '0; ci = '0; tag = '0;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_iter_count", iter_count_out, 0);
    check("rst_tag_out", tag_out, 0);

    // Immediate escape from 2.0, a short escape at c=0.5, and the cap at c=-1.0.
    send(20'h00800, 20'h0, 20'h00100, 20'h0, 19'h12345);
    drain();
    send(20'h0, 20'h0, 20'h00200, 20'h0, 19'h5A5A5);
    drain();
    send(20'h0, 20'h0, 20'hFFC00, 20'h0, 19'h00777);
    drain();

    // c == 0 freezes the count at 0; hold the result under backpressure.
    rdy_mode = 2;
    send(20'h00200, 20'h0, 20'h0, 20'h0, 19'h4CAFE);
    wait_valid();
    idle(10);
    check("bp_out_valid_held", out_valid, 1);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_count_held", iter_count_out, 0);
    check("bp_tag_held", tag_out, 19'h4CAFE);
    rdy_mode = 1;
    drain();

    // Abort mid-iteration discards the job; the next job still completes.
    send(20'h0, 20'h0, 20'h00200, 20'h0, 19'h01111);
    idle(2);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    idle(10);
    send(20'h0, 20'h0, 20'h00200, 20'h0, 19'h02222);
    drain();

    // Reset in the middle of a capped job.
    send(20'h0, 20'h0, 20'hFFC00, 20'h0, 19'h03333);
    idle(5);
    n_rst = 1'b0;
    idle(2);
    n_rst = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_iter_count", iter_count_out, 0);
    check("midrst_tag_out", tag_out, 0);
    idle(5);

    // Abort coinciding with an offered job: nothing is accepted.
    in_valid = 1'b1; abort = 1'b1;
    z0r = 20'h0; z0i = 20'h0; cr = 20'h00200; ci = 20'h0; tag = 19'h04444;
    idle(1);
    in_valid = 1'b0; abort = 1'b0;
    check("abort_vs_accept_in_ready", in_ready, 1);
    idle(10);

    // Abort while a result is held by backpressure clears the outputs.
    rdy_mode = 2;
    send(20'h00800, 20'h0, 20'h00100, 20'h0, 19'h05555);
    wait_valid();
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    check("abort_done_out_valid", out_valid, 0);
    check("abort_done_count", iter_count_out, 0);
    check("abort_done_tag", tag_out, 0);
    rdy_mode = 1;
    idle(5);

    // Randomised jobs with random backpressure: mostly in the +-2.0 window, some full range and c == 0.
    rdy_mode = 0;
    for (int j = 0; j < 40; j++) begin
      if (j % 5 == 4) begin
        ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); rd = W'($urandom);
      end else begin
        ra = W'($urandom_range(0, 4095) - 2048);
        rb = W'($urandom_range(0, 4095) - 2048);
        rc = W'($urandom_range(0, 2047) - 1024);
        rd = W'($urandom_range(0, 2047) - 1024);
      end
      if (j % 8 == 3) begin
        rc = '0; rd = '0;
      end
      send(ra, rb, rc, rd, TW'($urandom));
    end
    drain();
    rdy_mode = 1;
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
